// File: rtl/issue_slice.sv
// issue_slice: 2-entry registered AXI-Stream skid slice enforcing hazard lock/stall/flush.
// Define ISSUE_SLICE_PERF_EN to add the lock_cycles/stall_cycles hazard counters.
module issue_slice #(
    parameter int WIDTH = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic             lock,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       count
`ifdef ISSUE_SLICE_PERF_EN
    ,
    output logic [31:0]      lock_cycles,
    output logic [31:0]      stall_cycles
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] e1;
    logic             in_x;
    logic             out_x;

    assign count    = state;
    assign m_tvalid = (state != EMPTY) & ~lock;
    assign out_x    = m_tvalid & m_tready;
    assign in_x     = s_tvalid & s_tready & ~stall;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (state == EMPTY)
            state_nxt = in_x ? ONE : EMPTY;
        else if (state == ONE)
            state_nxt = (in_x == out_x) ? ONE : (in_x ? FULL : EMPTY);
        else
            state_nxt = out_x ? ONE : FULL;
    end

    // e0 lives directly in m_tdata; flush leaves both entries untouched
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= EMPTY;
            s_tready <= 1'b0;
            m_tdata  <= '0;
            e1       <= '0;
        end else begin
            state    <= state_nxt;
            s_tready <= state_nxt != FULL;
            if (!flush) begin
                if (in_x && (state == EMPTY || out_x))
                    m_tdata <= s_tdata;
                else if (out_x && state == FULL)
                    m_tdata <= e1;
                if (in_x && !out_x && state == ONE)
                    e1 <= s_tdata;
            end
        end
    end

`ifdef ISSUE_SLICE_PERF_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_cycles  <= '0;
            stall_cycles <= '0;
        end else begin
            if (lock && state != EMPTY)
                lock_cycles <= lock_cycles + 32'd1;
            if (stall && s_tvalid)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_issue_slice.sv
// tb_issue_slice: directed vector table, async-reset sequence and queue-model random run for issue_slice.
module tb_issue_slice;
    localparam int W = 16;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [W-1:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         lock;
    logic         stall;
    logic         flush;
    logic [1:0]   count;
`ifdef ISSUE_SLICE_PERF_EN
    logic [31:0]  lock_cycles;
    logic [31:0]  stall_cycles;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    issue_slice #(.WIDTH(W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .lock(lock), .stall(stall), .flush(flush), .count(count)
`ifdef ISSUE_SLICE_PERF_EN
        , .lock_cycles(lock_cycles), .stall_cycles(stall_cycles)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         mr;
        logic         lk;
        logic         st;
        logic         fl;
        logic [1:0]   e_cnt;
        logic         e_mv;
        logic         e_sr;
        logic         cd;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic mr,
                         input logic lk, input logic st, input logic fl);
        s_tvalid = v; s_tdata = d; m_tready = mr; lock = lk; stall = st; flush = fl;
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic mr, input logic lk,
                                input logic st, input logic fl, input logic [1:0] ec, input logic emv,
                                input logic esr, input logic cd, input logic [W-1:0] ed);
        vec_t r;
        r.v = v; r.d = d; r.mr = mr; r.lk = lk; r.st = st; r.fl = fl;
        r.e_cnt = ec; r.e_mv = emv; r.e_sr = esr; r.cd = cd; r.e_dat = ed;
        return r;
    endfunction

    logic [W-1:0] q[$];
    logic         rdy_m;
    logic         acc;
    logic [W-1:0] seq;
    logic         mv_m;
    logic         in_m;
    logic         out_m;

    initial begin
        // row fields: v d mr lock stall flush | count m_tvalid s_tready check_data data
        vt[0]  = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[1]  = mk(1, 'h1,  1, 0, 0, 0, 1, 1, 1, 1, 'h1);
        vt[2]  = mk(1, 'h2,  1, 0, 0, 0, 1, 1, 1, 1, 'h2);
        vt[3]  = mk(1, 'h3,  1, 0, 0, 0, 1, 1, 1, 1, 'h3);
        vt[4]  = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[5]  = mk(1, 'hA,  1, 1, 0, 0, 1, 0, 1, 1, 'hA);
        vt[6]  = mk(1, 'hB,  1, 1, 0, 0, 2, 0, 0, 1, 'hA);
        vt[7]  = mk(1, 'hC,  1, 1, 0, 0, 2, 0, 0, 1, 'hA);
        vt[8]  = mk(1, 'hC,  1, 1, 0, 0, 2, 0, 0, 1, 'hA);
        vt[9]  = mk(1, 'hC,  1, 0, 0, 0, 1, 1, 1, 1, 'hB);
        vt[10] = mk(1, 'hC,  1, 0, 0, 0, 1, 1, 1, 1, 'hC);
        vt[11] = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[12] = mk(1, 'h44, 0, 0, 0, 0, 1, 1, 1, 1, 'h44);
        vt[13] = mk(1, 'h55, 1, 0, 1, 0, 0, 0, 1, 0, 'h0);
        vt[14] = mk(1, 'h55, 1, 0, 1, 0, 0, 0, 1, 0, 'h0);
        vt[15] = mk(1, 'h55, 1, 0, 1, 0, 0, 0, 1, 0, 'h0);
        vt[16] = mk(1, 'h55, 1, 0, 1, 0, 0, 0, 1, 0, 'h0);
        vt[17] = mk(1, 'h55, 1, 0, 0, 0, 1, 1, 1, 1, 'h55);
        vt[18] = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[19] = mk(1, 'h10, 0, 0, 0, 0, 1, 1, 1, 1, 'h10);
        vt[20] = mk(1, 'h20, 0, 0, 0, 0, 2, 1, 0, 1, 'h10);
        vt[21] = mk(1, 'h30, 1, 0, 0, 1, 0, 0, 1, 0, 'h0);
        vt[22] = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[23] = mk(1, 'h66, 1, 0, 0, 0, 1, 1, 1, 1, 'h66);
        vt[24] = mk(1, 'h77, 1, 1, 1, 0, 1, 0, 1, 1, 'h66);
        vt[25] = mk(0, 'h0,  1, 0, 0, 0, 0, 0, 1, 0, 'h0);

        drive(0, '0, 0, 0, 0, 0);
        aresetn = 1'b0;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        tick(); tick(); tick();
        aresetn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vt[i].v, vt[i].d, vt[i].mr, vt[i].lk, vt[i].st, vt[i].fl);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(vt[i].e_mv));
            chk($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(vt[i].e_sr));
            if (vt[i].cd)
                chk($sformatf("vec%0d_m_tdata", i), 32'(m_tdata), 32'(vt[i].e_dat));
        end

        // asynchronous reset while FULL, asserted between edges
        drive(1, 'h81, 0, 0, 0, 0);
        tick();
        drive(1, 'h82, 0, 0, 0, 0);
        tick();
        drive(0, '0, 0, 0, 0, 0);
        chk("ar_full", 32'(count), 2);
        #3;
        aresetn = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_m_tvalid", 32'(m_tvalid), 0);
        chk("ar_s_tready", 32'(s_tready), 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        chk("ar_rel_s_tready", 32'(s_tready), 1);
        drive(1, 'h90, 0, 0, 0, 0);
        tick();
        chk("ar_new_count", 32'(count), 1);
        chk("ar_new_data", 32'(m_tdata), 'h90);
        drive(0, '0, 1, 0, 0, 0);
        tick();
        chk("ar_drain", 32'(count), 0);

        // randomized run against a queue model
        drive(0, '0, 0, 0, 0, 0);
        do_reset();
        q.delete();
        rdy_m = 1'b0;
        acc = 1'b0;
        seq = 16'h100;
        for (int c = 0; c < 3000; c++) begin
            if (!s_tvalid || acc) begin
                s_tvalid = $urandom_range(0, 3) != 0;
                if (s_tvalid) begin
                    s_tdata = seq;
                    seq = seq + 1'b1;
                end
            end
            m_tready = $urandom_range(0, 3) != 0;
            lock = $urandom_range(0, 3) == 0;
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 19) == 0;
            #1;
            mv_m = (q.size() != 0) && !lock;
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_m_tvalid", 32'(m_tvalid), 32'(mv_m));
            chk("rnd_s_tready", 32'(s_tready), 32'(rdy_m));
            if (mv_m)
                chk("rnd_m_tdata", 32'(m_tdata), 32'(q[0]));
            in_m = s_tvalid && rdy_m && !stall;
            out_m = mv_m && m_tready;
            acc = in_m;
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (out_m) void'(q.pop_front());
                if (in_m) q.push_back(s_tdata);
            end
            rdy_m = flush || q.size() <= 1;
        end

`ifdef ISSUE_SLICE_PERF_EN
        drive(0, '0, 0, 0, 0, 0);
        do_reset();
        tick();
        drive(1, 'hE1, 0, 0, 0, 0);
        tick();
        drive(0, '0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        drive(1, 'hE2, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("perf_lock", lock_cycles, 5);
        chk("perf_stall", stall_cycles, 3);
        drive(0, '0, 0, 0, 0, 1);
        tick();
        drive(0, '0, 0, 0, 0, 0);
        tick();
        chk("perf_flush_count", 32'(count), 0);
        chk("perf_lock_kept", lock_cycles, 5);
        chk("perf_stall_kept", stall_cycles, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
